// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the byte-wide RAM port arbiter:
//   - arb_state_t     : sequencer state encoding (IDLE, IF_RD, MEM_RD, MEM_WR)
//   - SEL_*           : mem_sel access-size encodings
//   - N_*             : byte-count decode constants
//   - RST_ENABLE      : active level of rst
//   - STOP / NO_STOP  : levels driven on the stall-request outputs
//   - sel_to_n()      : mem_sel -> byte count
//   - pick_byte()     : little-endian byte lane select
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } arb_state_t;

    localparam logic [1:0] SEL_BYTE     = 2'b00;
    localparam logic [1:0] SEL_HALF     = 2'b01;
    localparam logic [1:0] SEL_WORD     = 2'b10;
    localparam logic [1:0] SEL_WORD_ALT = 2'b11;

    localparam logic [2:0] N_BYTE = 3'd1;
    localparam logic [2:0] N_HALF = 3'd2;
    localparam logic [2:0] N_WORD = 3'd4;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

    function automatic logic [2:0] sel_to_n(input logic [1:0] sel);
        case (sel)
            SEL_BYTE:               sel_to_n = N_BYTE;
            SEL_HALF:               sel_to_n = N_HALF;
            SEL_WORD, SEL_WORD_ALT: sel_to_n = N_WORD;
            default:                sel_to_n = N_WORD;
        endcase
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    pick_byte = word[7:0];
            2'd1:    pick_byte = word[15:8];
            2'd2:    pick_byte = word[23:16];
            default: pick_byte = word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_assembler.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_byte_assembler
// Read-path lane shift register. Each captured RAM byte enters at the top lane
// and older bytes move down, so after n shifts the first byte of the access
// sits in the lowest of the n top lanes. The word output is the value the
// register would hold after shifting in din this cycle, right-aligned and
// zero-extended to the access size, so the owner can register the finished
// word in the same cycle it captures the last byte.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   shift_en  : capture din into the top lane
//   din [7:0] : RAM read byte
//   n [2:0]   : access byte count (1, 2 or 4)
//   word[31:0]: assembled, zero-extended data including din
// -----------------------------------------------------------------------------
module mem_port_arbiter_byte_assembler
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic [7:0]  din,
    input  logic [2:0]  n,
    output logic [31:0] word
);

    logic [31:0] lanes;
    logic [31:0] lanes_next;

    assign lanes_next = {din, lanes[31:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            lanes <= '0;
        end else if (shift_en) begin
            lanes <= lanes_next;
        end
    end

    always_comb begin
        word = lanes_next;
        case (n)
            N_BYTE:  word = {24'd0, lanes_next[31:24]};
            N_HALF:  word = {16'd0, lanes_next[31:16]};
            default: word = lanes_next;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Sequencer/arbiter for the CPU's single byte-wide RAM port, shared between
// instruction fetch (always 32-bit) and the data stage (byte/half/word loads
// and stores). Requests are split into little-endian byte accesses; read
// bytes are reassembled by mem_port_arbiter_byte_assembler.
//
// Optional feature: define MEM_ARB_IFBUF_EN to add a one-entry fetch buffer
// (tag, word, valid). A fetch whose address matches the valid tag completes
// from IDLE with no RAM traffic; every completed RAM fetch refills it; any
// store accept invalidates it.
//
// Request handshake: a requester raises *_req with stable address/data and
// holds it until the matching *_done pulse; *_done is a one-cycle pulse with
// *_data/*_rdata valid in that cycle. The done cycle never accepts a new
// request, so a requester may drop or change its request on seeing done.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   rdy_in              : global ready; low freezes all state
//   flush               : aborts an in-flight fetch, blocks a fetch accept
//   if_req/if_addr      : fetch request and address
//   if_data/if_done     : fetched word and completion pulse
//   mem_req/mem_we/mem_sel/mem_addr/mem_wdata : data request
//   mem_rdata/mem_done  : zero-extended load data and completion pulse
//   ram_din             : RAM read byte (one cycle after its address)
//   ram_dout/ram_a/ram_wr : registered RAM write byte, address, strobe
//   stall_req_if/mem    : req & ~done, to the pipeline stall controller
//   dbg_state           : current sequencer state
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              stall_req_if,
    output logic              stall_req_mem,
    output arb_state_t        dbg_state
);

    arb_state_t        state;
    logic [2:0]        cnt;
    logic [2:0]        n_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic              if_done_q;
    logic              mem_done_q;
    logic              ram_wr_q;

    logic [2:0]        cnt_next;
    logic [ADDR_W-1:0] addr_next;
    logic              done_busy;
    logic              is_read;
    logic              asm_shift;
    logic [31:0]       asm_word;

`ifdef MEM_ARB_IFBUF_EN
    logic [ADDR_W-1:0] buf_tag;
    logic [31:0]       buf_word;
    logic              buf_valid;
    logic              buf_hit;

    assign buf_hit = buf_valid && (buf_tag == if_addr);
`endif

    assign cnt_next  = cnt + 3'd1;
    // Address of the next byte; wraps naturally modulo 2^ADDR_W.
    assign addr_next = base_q + {{(ADDR_W-3){1'b0}}, cnt_next};
    assign done_busy = if_done_q | mem_done_q;
    assign is_read   = (state == ST_IF_RD) || (state == ST_MEM_RD);
    // In a read state with cnt=k>0, ram_din carries byte k-1.
    assign asm_shift = rdy_in && is_read && (cnt != 3'd0);

    // While frozen, the write strobe and done pulses are masked but held, so
    // the interrupted step replays unchanged once rdy_in returns.
    assign ram_wr        = ram_wr_q & rdy_in;
    assign if_done       = if_done_q & rdy_in;
    assign mem_done      = mem_done_q & rdy_in;
    assign stall_req_if  = (if_req & ~if_done) ? STOP : NO_STOP;
    assign stall_req_mem = (mem_req & ~mem_done) ? STOP : NO_STOP;
    assign dbg_state     = state;

    mem_port_arbiter_byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .shift_en (asm_shift),
        .din      (ram_din),
        .n        (n_q),
        .word     (asm_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            n_q        <= N_WORD;
            base_q     <= '0;
            wdata_q    <= '0;
            ram_a      <= '0;
            ram_dout   <= 8'd0;
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            if_data    <= 32'd0;
            mem_rdata  <= 32'd0;
`ifdef MEM_ARB_IFBUF_EN
            buf_tag    <= '0;
            buf_word   <= 32'd0;
            buf_valid  <= 1'b0;
`endif
        end else if (rdy_in) begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= 3'd0;
                    if (mem_req && !done_busy) begin
                        // Data stage has priority over fetch.
                        base_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        n_q     <= sel_to_n(mem_sel);
                        ram_a   <= mem_addr;
                        if (mem_we) begin
                            state    <= ST_MEM_WR;
                            ram_dout <= mem_wdata[7:0];
                            ram_wr_q <= 1'b1;
`ifdef MEM_ARB_IFBUF_EN
                            buf_valid <= 1'b0;
`endif
                        end else begin
                            state <= ST_MEM_RD;
                        end
                    end else if (if_req && !flush && !done_busy) begin
`ifdef MEM_ARB_IFBUF_EN
                        if (buf_hit) begin
                            if_done_q <= 1'b1;
                            if_data   <= buf_word;
                        end else begin
`endif
                            base_q <= if_addr;
                            n_q    <= N_WORD;
                            ram_a  <= if_addr;
                            state  <= ST_IF_RD;
`ifdef MEM_ARB_IFBUF_EN
                        end
`endif
                    end
                end

                ST_IF_RD, ST_MEM_RD: begin
                    if ((state == ST_IF_RD) && flush) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                    end else if (cnt == n_q) begin
                        // Last byte is on ram_din now; asm_word includes it.
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                        if (state == ST_IF_RD) begin
                            if_done_q <= 1'b1;
                            if_data   <= asm_word;
`ifdef MEM_ARB_IFBUF_EN
                            buf_tag   <= base_q;
                            buf_word  <= asm_word;
                            buf_valid <= 1'b1;
`endif
                        end else begin
                            mem_done_q <= 1'b1;
                            mem_rdata  <= asm_word;
                        end
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next < n_q) begin
                            ram_a <= addr_next;
                        end
                    end
                end

                ST_MEM_WR: begin
                    if (cnt_next < n_q) begin
                        cnt      <= cnt_next;
                        ram_a    <= addr_next;
                        ram_dout <= pick_byte(wdata_q, cnt_next[1:0]);
                        ram_wr_q <= 1'b1;
                    end else begin
                        cnt        <= 3'd0;
                        ram_wr_q   <= 1'b0;
                        mem_done_q <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              rdy_in;
    logic              flush;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              stall_req_if;
    logic              stall_req_mem;
    arb_state_t        dbg_state;

    int          n_cmp;
    int          n_fail;
    logic [39:0] exp_q[$];

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy_in        (rdy_in),
        .flush         (flush),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_data       (if_data),
        .if_done       (if_done),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_sel       (mem_sel),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_done      (mem_done),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .ram_a         (ram_a),
        .ram_wr        (ram_wr),
        .stall_req_if  (stall_req_if),
        .stall_req_mem (stall_req_mem),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM read model ----------------
    function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
        case (a)
            32'h0000_1000: rom_byte = 8'h13;
            32'h0000_1001: rom_byte = 8'h05;
            32'h0000_1002: rom_byte = 8'h00;
            32'h0000_1003: rom_byte = 8'h00;
            32'h0000_2003: rom_byte = 8'hFF;
            default:       rom_byte = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) ram_din <= rom_byte(ram_a);

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch in the current cycle (cycle 0) and wait for if_done.
    task automatic run_if(input logic [ADDR_W-1:0] addr, output int cyc,
                          output logic [31:0] data, output logic stall_ok);
        if_addr = addr;
        if_req  = 1'b1;
        #1;
        stall_ok = (stall_req_if === 1'b1);
        cyc  = -1;
        data = '0;
        for (int c = 1; c <= 20 && cyc < 0; c++) begin
            tick();
            if (if_done === 1'b1) begin
                cyc  = c;
                data = if_data;
                if (stall_req_if !== 1'b0) stall_ok = 1'b0;
            end else if (stall_req_if !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic run_mem(input logic we, input logic [1:0] sel,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                           output int cyc, output logic [31:0] rdata);
        mem_we    = we;
        mem_sel   = sel;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_req   = 1'b1;
        cyc   = -1;
        rdata = '0;
        for (int c = 1; c <= 20 && cyc < 0; c++) begin
            tick();
            if (mem_done === 1'b1) begin
                cyc   = c;
                rdata = mem_rdata;
            end
        end
        mem_req = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int          cyc;
        logic [31:0] data;
        logic        sok;
        repeat (2) tick();
        n_cmp++;
        if ({ram_a, ram_dout, ram_wr, if_done, mem_done, if_data, mem_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a=%h d=%h wr=%b ifd=%b md=%b ifdat=%h mrd=%h required all zero",
                     ram_a, ram_dout, ram_wr, if_done, mem_done, if_data, mem_rdata);
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        tick();
        // Start a word fetch, then reset while byte 2 is addressed.
        if_addr = 32'h1000;
        if_req  = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (ram_a !== 32'h1002) begin
            n_fail++;
            $display("FAIL midread_ram_a: got %h required %h", ram_a, 32'h1002);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_a, ram_dout, ram_wr, if_done, mem_done, if_data, mem_rdata} !== '0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midread_reset: got a=%h wr=%b ifd=%b state=%0d required zero/idle",
                     ram_a, ram_wr, if_done, dbg_state);
        end
        if_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        run_if(32'h1000, cyc, data, sok);
        n_cmp++;
        if (cyc !== 6 || data !== 32'h0000_0513) begin
            n_fail++;
            $display("FAIL post_reset_fetch: got cyc=%0d data=%h required cyc=6 data=00000513", cyc, data);
        end
        n_cmp++;
        if (sok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_req_if_window: got %b required 1", sok);
        end
        tick();
    endtask

    task automatic test_if_read();
        int          cyc;
        logic [31:0] data;
        logic        sok;
        run_if(32'h10FC, cyc, data, sok);
        n_cmp++;
        if (cyc !== 6 || data !== 32'h5A5B_5859) begin
            n_fail++;
            $display("FAIL fetch_10fc: got cyc=%0d data=%h required cyc=6 data=5a5b5859", cyc, data);
        end
        tick();
        run_if(32'hFFFF_FFFE, cyc, data, sok);
        n_cmp++;
        if (cyc !== 6 || data !== 32'hA4A5_5A5B) begin
            n_fail++;
            $display("FAIL fetch_wrap: got cyc=%0d data=%h required cyc=6 data=a4a55a5b", cyc, data);
        end
        tick();
    endtask

    task automatic test_priority();
        int              mem_cyc;
        int              if_cyc;
        logic [31:0]     mem_dat;
        logic [31:0]     if_dat;
        logic [ADDR_W-1:0] a1;
        logic            smem2;
        logic            smem3;
        mem_we   = 1'b0;
        mem_sel  = SEL_BYTE;
        mem_addr = 32'h2003;
        mem_req  = 1'b1;
        if_addr  = 32'h1100;
        if_req   = 1'b1;
        mem_cyc = -1; if_cyc = -1; mem_dat = '0; if_dat = '0;
        a1 = '0; smem2 = 1'b0; smem3 = 1'b1;
        for (int c = 1; c <= 30 && if_cyc < 0; c++) begin
            tick();
            if (c == 1) a1 = ram_a;
            if (c == 2) smem2 = stall_req_mem;
            if (mem_done === 1'b1 && mem_cyc < 0) begin
                mem_cyc = c;
                mem_dat = mem_rdata;
                smem3   = stall_req_mem;
                mem_req = 1'b0;
            end
            if (if_done === 1'b1 && if_cyc < 0) begin
                if_cyc = c;
                if_dat = if_data;
            end
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        n_cmp++;
        if (a1 !== 32'h2003) begin
            n_fail++;
            $display("FAIL prio_first_addr: got %h required 00002003", a1);
        end
        n_cmp++;
        if (mem_cyc !== 3 || mem_dat !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL prio_mem_load: got cyc=%0d data=%h required cyc=3 data=000000ff", mem_cyc, mem_dat);
        end
        n_cmp++;
        if (smem2 !== 1'b1 || smem3 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_req_mem: got c2=%b c3=%b required 1/0", smem2, smem3);
        end
        n_cmp++;
        if (if_cyc !== 10 || if_dat !== 32'hA6A7_A4A5) begin
            n_fail++;
            $display("FAIL prio_if_after: got cyc=%0d data=%h required cyc=10 data=a6a7a4a5", if_cyc, if_dat);
        end
        tick();
    endtask

    task automatic test_load_sizes();
        int          cyc;
        logic [31:0] data;
        run_mem(1'b0, SEL_WORD_ALT, 32'h2000, 32'h0, cyc, data);
        n_cmp++;
        if (cyc !== 6 || data !== 32'hFFA7_A4A5) begin
            n_fail++;
            $display("FAIL load_word_sel11: got cyc=%0d data=%h required cyc=6 data=ffa7a4a5", cyc, data);
        end
        tick();
        run_mem(1'b0, SEL_HALF, 32'h2002, 32'h0, cyc, data);
        n_cmp++;
        if (cyc !== 4 || data !== 32'h0000_FFA7) begin
            n_fail++;
            $display("FAIL load_half: got cyc=%0d data=%h required cyc=4 data=0000ffa7", cyc, data);
        end
        tick();
    endtask

    task automatic test_store_half();
        int          wr_cnt;
        int          first_wr;
        int          done_cyc;
        logic [39:0] e;
        exp_q.push_back({32'h3000, 8'hEF});
        exp_q.push_back({32'h3001, 8'hBE});
        mem_we    = 1'b1;
        mem_sel   = SEL_HALF;
        mem_addr  = 32'h3000;
        mem_wdata = 32'h1234_BEEF;
        mem_req   = 1'b1;
        wr_cnt = 0; first_wr = -1; done_cyc = -1;
        for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
            tick();
            if (ram_wr === 1'b1) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = c;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 40'h0;
                n_cmp++;
                if ({ram_a, ram_dout} !== e) begin
                    n_fail++;
                    $display("FAIL store_half_byte: got a=%h d=%h required a=%h d=%h",
                             ram_a, ram_dout, e[39:8], e[7:0]);
                end
            end
            if (mem_done === 1'b1) done_cyc = c;
        end
        mem_req = 1'b0;
        mem_we  = 1'b0;
        n_cmp++;
        if (wr_cnt !== 2 || first_wr !== 1 || done_cyc !== 3 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL store_half_timing: got writes=%0d first=%0d done=%0d left=%0d required 2/1/3/0",
                     wr_cnt, first_wr, done_cyc, exp_q.size());
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_rdy_stall();
        int          wr_cnt;
        int          done_cyc;
        logic [39:0] e;
        exp_q.push_back({32'h3100, 8'hD4});
        exp_q.push_back({32'h3101, 8'hC3});
        exp_q.push_back({32'h3102, 8'hB2});
        exp_q.push_back({32'h3103, 8'hA1});
        mem_we    = 1'b1;
        mem_sel   = SEL_WORD;
        mem_addr  = 32'h3100;
        mem_wdata = 32'hA1B2_C3D4;
        mem_req   = 1'b1;
        wr_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            tick();
            rdy_in = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            #1;
            if (ram_wr === 1'b1) begin
                wr_cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 40'h0;
                n_cmp++;
                if ({ram_a, ram_dout} !== e) begin
                    n_fail++;
                    $display("FAIL rdy_store_byte: got a=%h d=%h required a=%h d=%h",
                             ram_a, ram_dout, e[39:8], e[7:0]);
                end
            end
            if (mem_done === 1'b1) done_cyc = c;
        end
        rdy_in  = 1'b1;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        n_cmp++;
        if (wr_cnt !== 4 || done_cyc !== 8 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rdy_store_timing: got writes=%0d done=%0d left=%0d required 4/8/0",
                     wr_cnt, done_cyc, exp_q.size());
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_flush();
        int seen;
        if_addr = 32'h1200;
        if_req  = 1'b1;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        n_cmp++;
        if (dbg_state !== ST_IDLE || if_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_abort: got state=%0d if_done=%b required %0d/0", dbg_state, if_done, ST_IDLE);
        end
        flush  = 1'b0;
        if_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (if_done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_no_done: got %0d pulses required 0", seen);
        end
        // Flush in IDLE blocks the fetch accept for that cycle only.
        if_req = 1'b1;
        flush  = 1'b1;
        tick();
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL flush_blocks_accept: got state=%0d required %0d", dbg_state, ST_IDLE);
        end
        flush = 1'b0;
        tick();
        n_cmp++;
        if (dbg_state !== ST_IF_RD) begin
            n_fail++;
            $display("FAIL accept_after_flush: got state=%0d required %0d", dbg_state, ST_IF_RD);
        end
        flush = 1'b1;
        tick();
        flush  = 1'b0;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int          c1;
        int          c2;
        logic [31:0] d1;
        logic [31:0] d2;
        c1 = -1; c2 = -1; d1 = '0; d2 = '0;
        if_addr = 32'h1300;
        if_req  = 1'b1;
        for (int c = 1; c <= 30 && c2 < 0; c++) begin
            tick();
            if (if_done === 1'b1) begin
                if (c1 < 0) begin
                    c1 = c;
                    d1 = if_data;
                    if_addr = 32'h1304;
                end else begin
                    c2 = c;
                    d2 = if_data;
                end
            end
        end
        if_req = 1'b0;
        n_cmp++;
        if (c1 !== 6 || d1 !== 32'hA6A7_A4A5) begin
            n_fail++;
            $display("FAIL b2b_first: got cyc=%0d data=%h required cyc=6 data=a6a7a4a5", c1, d1);
        end
        n_cmp++;
        if (c2 !== 13 || d2 !== 32'hA2A3_A0A1) begin
            n_fail++;
            $display("FAIL b2b_second: got cyc=%0d data=%h required cyc=13 data=a2a3a0a1", c2, d2);
        end
        tick();
    endtask

`ifdef MEM_ARB_IFBUF_EN
    task automatic test_ifbuf();
        int                cyc;
        logic [31:0]       data;
        logic              sok;
        logic [ADDR_W-1:0] a_before;
        logic [31:0]       rd;
        run_if(32'h1400, cyc, data, sok);
        n_cmp++;
        if (cyc !== 6 || data !== 32'hA6A7_A4A5) begin
            n_fail++;
            $display("FAIL ifbuf_fill: got cyc=%0d data=%h required cyc=6 data=a6a7a4a5", cyc, data);
        end
        tick();
        a_before = ram_a;
        run_if(32'h1400, cyc, data, sok);
        n_cmp++;
        if (cyc !== 1 || data !== 32'hA6A7_A4A5 || ram_a !== a_before) begin
            n_fail++;
            $display("FAIL ifbuf_hit: got cyc=%0d data=%h ram_a=%h required cyc=1 data=a6a7a4a5 ram_a=%h",
                     cyc, data, ram_a, a_before);
        end
        tick();
        run_mem(1'b1, SEL_BYTE, 32'h3200, 32'h0000_0055, cyc, rd);
        tick();
        run_if(32'h1400, cyc, data, sok);
        n_cmp++;
        if (cyc !== 6 || data !== 32'hA6A7_A4A5) begin
            n_fail++;
            $display("FAIL ifbuf_invalidate: got cyc=%0d data=%h required cyc=6 data=a6a7a4a5", cyc, data);
        end
        tick();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        rdy_in    = 1'b1;
        flush     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;

        test_reset();
        test_if_read();
        test_priority();
        test_load_sizes();
        test_store_half();
        test_rdy_stall();
        test_flush();
        test_back_to_back();
`ifdef MEM_ARB_IFBUF_EN
        test_ifbuf();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the CPU's single byte-wide RAM port. It is shared between the IF stage (32-bit instruction fetch) and the MEM stage (byte, half and word loads and stores). Each accepted request is split into little-endian byte accesses and the result is reassembled. The block drives the `stall_req_if` and `stall_req_mem` inputs of the pipeline stall controller and honours `rdy_in` and pipeline flush.

## Interface
Parameters:
- `ADDR_W`, 32: RAM address width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global ready; low freezes the block.
- `flush` in 1: pipeline flush; aborts an in-flight IF read.
- `if_req` in 1: instruction fetch request, held until `if_done`.
- `if_addr` in ADDR_W: fetch address.
- `if_data` out 32: fetched word, valid while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse.
- `mem_req` in 1: data request, held until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_sel` in 2: access size; 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `mem_addr` in ADDR_W: data address.
- `mem_wdata` in 32: store data; low bytes are used.
- `mem_rdata` out 32: load data, zero-extended, valid while `mem_done`=1.
- `mem_done` out 1: one-cycle completion pulse.
- `ram_din` in 8: RAM read byte, valid one cycle after its address.
- `ram_dout` out 8: RAM write byte.
- `ram_a` out ADDR_W: RAM byte address.
- `ram_wr` out 1: RAM write strobe.
- `stall_req_if` out 1: equals `if_req & ~if_done`.
- `stall_req_mem` out 1: equals `mem_req & ~mem_done`.

## Operation
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter `cnt` is 3 bits. Byte count `n` is 4 for IF and 1/2/4 for MEM per `mem_sel`.
- IDLE arbitration: `mem_req` has priority over `if_req`. The chosen request is latched (address, data, `n`) and the FSM moves to the matching state with `cnt`=0.
- Read states: cycle k drives `ram_a` = base+k for k < n. The byte arriving in the following cycle is stored into lane k. After lane n-1 is captured, the done pulse is raised and the FSM returns to IDLE.
- MEM_WR: cycle k drives `ram_a` = base+k, `ram_dout` = wdata[8k+7:8k] and `ram_wr`=1 for k < n. Then `mem_done` is pulsed and the FSM returns to IDLE.
- A completed request is never re-accepted in its done cycle. IDLE requires one cycle before the next accept.
- `flush`=1 in IF_RD aborts the read: the FSM goes to IDLE and no `if_done` is produced. `flush` does not affect MEM states, and does not affect IDLE beyond blocking an IF accept in that cycle.
- `rdy_in`=0: state, counter and data registers hold. `ram_wr` is forced to 0 and done pulses are suppressed until `rdy_in` returns.
- Address arithmetic is modulo 2^ADDR_W; base+k wraps.
- Reset values: state IDLE, `cnt`=0, `ram_a`=0, `ram_dout`=0, `ram_wr`=0, `if_done`=0, `mem_done`=0, `if_data`=0, `mem_rdata`=0.

## Timing
- Accept at edge E0 (the request was seen in IDLE). Byte k address is on `ram_a` in cycle k+1. `ram_a`, `ram_dout` and `ram_wr` are registered.
- Read of n bytes: the done pulse is in cycle n+2 after E0 (word read: 6). Data is registered alongside the pulse.
- Write of n bytes: `ram_wr` is high in cycles 1..n and `mem_done` is in cycle n+1.
- The stall outputs are combinational from the req and done signals, with zero latency.

## Configuration
- `MEM_ARB_IFBUF_EN` defined:
  - Adds a one-entry fetch buffer (tag, word, valid).
  - An IF request whose address equals the valid tag completes in IDLE with `if_done` on the next cycle and no RAM traffic.
  - The buffer is filled on every completed IF read.
  - Valid is cleared on reset and on any MEM_WR accept.
- `MEM_ARB_IFBUF_EN` undefined: every fetch goes to RAM; no buffer logic exists.

## Structure
- Shared defines file: state encodings, `mem_sel` encodings, byte-count decode constants, and `Stop` and `RstEnable` levels.
- Natural sub-module `byte_assembler`: the lane shift register plus zero-extension, instantiated once for the read path.

## Test plan
- Reset mid-word-read (`cnt`=2): all outputs return to reset values at once; the next `if_req` to 0x1000 completes normally 6 cycles after accept.
- IF word read at 0x1000 with RAM bytes 0x13,0x05,0x00,0x00: `if_data`=0x00000513 and `if_done` in cycle 6; `stall_req_if` is high in cycles 0–5.
- Simultaneous `mem_req` (load byte at 0x2003 = 0xFF) and `if_req`: MEM is served first and `mem_rdata`=0x000000FF in cycle 3. IF is accepted afterwards.
- Store half 0xBEEF at 0x3000: `ram_wr` is high for 2 cycles with (0x3000, 0xEF), (0x3001, 0xBE); `mem_done` in cycle 3.
- `flush` in cycle 3 of an IF read: no `if_done` and state is IDLE the next cycle. `rdy_in` low for 3 cycles mid-store: the write sequence resumes intact, with done delayed by exactly 3 cycles.
- With `MEM_ARB_IFBUF_EN`: a repeat fetch of 0x1000 completes in 1 cycle with no `ram_a` change. After an intervening store, the same fetch takes 6 cycles.
